ecc_145_err_monitor: RTL and testbench
======================================

// Module: ecc_145_err_monitor
// PURPOSE
//  Read-side stage directly downstream of the 145-bit ECC fault-detect stage in the FIFO read path.
//  - Accepts each corrected beat with its status flags: sbit_err, dbit_err, ecc_fault.
//  - Buffers accepted beats in a 2-entry skid buffer under valid/ready handshake, tagging
//    uncorrectable beats with a poison bit.
//  - Keeps saturating error counters and a sticky interrupt for the safety/status register block.
// PARAMETERS
//  DATA_WIDTH  145  width of corrected data beat
//  ADDR_WIDTH  8    width of FIFO read address carried with each beat
//  CNT_WIDTH   16   width of each saturating event counter
// PORTS
//  clk        in   1           single clock
//  rst        in   1           synchronous reset, active-high
//  in_vld     in   1           upstream beat valid
//  in_rdy     out  1           upstream beat accepted when in_vld & in_rdy
//  in_addr    in   ADDR_WIDTH  FIFO read address of beat
//  in_data    in   DATA_WIDTH  corrected data from fault-detect stage
//  sbit_err   in   1           single-bit error corrected
//  dbit_err   in   1           double-bit error detected, uncorrectable
//  ecc_fault  in   1           dual-decoder mismatch
//  out_vld    out  1           downstream beat valid
//  out_rdy    in   1           downstream ready
//  out_data   out  DATA_WIDTH  buffered data
//  out_poison out  1           beat had dbit_err | ecc_fault
//  irq_en     in   1           enable interrupt set
//  irq_clr    in   1           one-cycle pulse, clears irq
//  cnt_clr    in   1           one-cycle pulse, clears all counters (and error log)
//  sbit_cnt   out  CNT_WIDTH   accepted beats with sbit_err
//  dbit_cnt   out  CNT_WIDTH   accepted beats with dbit_err
//  fault_cnt  out  CNT_WIDTH   accepted beats with ecc_fault
//  irq        out  1           sticky interrupt, level
//  err_log_vld out 1           first-error log valid (macro only)
//  err_addr   out  ADDR_WIDTH  address of first logged error (macro only)
//  err_type   out  3           {ecc_fault,dbit_err,sbit_err} of first error (macro only)
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): buffer empty; out_vld=0; out_data=0; out_poison=0; all counters 0;
//    irq=0; err_log_vld=0; err_addr=0; err_type=0. Reset mid-transfer discards buffered beats.
//  - Buffer: 2 entries, FIFO order; occupancy count 0..2 registered.
//  - in_rdy = (count<2), derived from registered state only; no combinational path from out_rdy.
//  - Latency: a beat accepted into an empty buffer gives out_vld=1 on the next cycle.
//    Full throughput 1 beat/cycle while out_rdy=1.
//  - Pop on out_vld & out_rdy. Push and pop in the same cycle at count 1: count stays 1, data advances.
//  - out_data/out_poison hold stable while out_vld=1 & out_rdy=0.
//  - Status flags are sampled only on accept (in_vld & in_rdy); flags on non-accepted cycles are ignored.
//  - Counters:
//    - Each counter increments by 1 per accepted beat with its flag set.
//    - Saturate at 2^CNT_WIDTH-1; no wrap.
//    - Multiple flags on one beat increment each matching counter.
//    - cnt_clr and event in the same cycle: counter loads 1 (clear then count).
//  - irq:
//    - Set on an accepted beat with (dbit_err | ecc_fault) & irq_en. sbit_err alone never sets irq.
//    - Cleared by irq_clr; set has priority over a simultaneous irq_clr.
//    - Holds when irq_en is deasserted.
// CONFIGURATION
//  ECC_145_ERR_LOG_EN defined:
//   - First accepted beat with any flag set, while err_log_vld=0, captures in_addr into err_addr and
//     flags into err_type; err_log_vld <= 1.
//   - Later errors do not overwrite the log.
//   - cnt_clr clears the log. An error in the same cycle as cnt_clr is captured (err_log_vld=1 next cycle).
//  ECC_145_ERR_LOG_EN undefined: err_log_vld, err_addr, err_type tied to 0; no log registers.
// TESTING
//  1. Reset, then 4 clean beats with out_rdy=1 -> each emerges 1 cycle later, poison=0, counters 0, irq=0.
//  2. out_rdy=0, push 3 beats -> 2 accepted, in_rdy=0 on 3rd; out_rdy=1 -> beats drain in order,
//     third beat accepted once count<2.
//  3. Beat with sbit_err=1, then beat with dbit_err=1, irq_en=1 -> sbit_cnt=1, dbit_cnt=1,
//     second beat out_poison=1, irq=1.
//  4. CNT_WIDTH=4: 20 sbit beats -> sbit_cnt holds at 15; cnt_clr with a concurrent sbit beat -> sbit_cnt=1.
//  5. irq_clr in the same cycle as an accepted ecc_fault beat -> irq stays 1, fault_cnt=1;
//     irq_clr alone next cycle -> irq=0.
//  6. Macro on: first error at addr 0x12, second at 0x34 -> err_addr=0x12; cnt_clr -> err_log_vld=0.
//     Macro off -> log outputs always 0.

Source files
------------

// File: rtl/ecc_145_err_monitor.sv
// Error monitor after the 145-bit ECC fault-detect stage: 2-entry skid buffer with poison tagging,
// saturating error counters and a sticky irq. Define ECC_145_ERR_LOG_EN to add the first-error log.
module ecc_145_err_monitor #(
  parameter int unsigned DATA_WIDTH = 145,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  sbit_err,
  input  logic                  dbit_err,
  input  logic                  ecc_fault,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_poison,
  input  logic                  irq_en,
  input  logic                  irq_clr,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic [CNT_WIDTH-1:0]  fault_cnt,
  output logic                  irq,
  output logic                  err_log_vld,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [2:0]            err_type
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]            count;
  logic [1:0]            count_nxt_c;
  logic [DATA_WIDTH-1:0] tail_data;
  logic                  tail_poison;
  logic                  push_c;
  logic                  pop_c;
  logic                  poison_c;
  logic                  wr_head_c;

  assign push_c    = in_vld & in_rdy;
  assign pop_c     = out_vld & out_rdy;
  assign poison_c  = dbit_err | ecc_fault;
  // Incoming beat lands at the head when the buffer is, or is about to become, empty.
  assign wr_head_c = push_c & ((count == 2'd0) | ((count == 2'd1) & pop_c));

  always_comb begin
    count_nxt_c = count;
    case ({push_c, pop_c})
      2'b10:   count_nxt_c = 2'(count + 2'd1);
      2'b01:   count_nxt_c = 2'(count - 2'd1);
      default: count_nxt_c = count;
    endcase
  end

  function automatic logic [CNT_WIDTH-1:0] cnt_upd(input logic [CNT_WIDTH-1:0] cur,
                                                   input logic clr, input logic ev);
    logic [CNT_WIDTH-1:0] base;
    base = clr ? '0 : cur;
    if (ev && (base != CNT_MAX)) base = CNT_WIDTH'(base + 1'b1);
    return base;
  endfunction

  // Skid buffer: out_data/out_poison are the head entry, tail_* the second entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= 2'd0;
      in_rdy      <= 1'b1;
      out_vld     <= 1'b0;
      out_data    <= '0;
      out_poison  <= 1'b0;
      tail_data   <= '0;
      tail_poison <= 1'b0;
    end else begin
      count   <= count_nxt_c;
      out_vld <= (count_nxt_c != 2'd0);
      in_rdy  <= (count_nxt_c != 2'd2);
      if (pop_c && (count == 2'd2)) begin
        out_data   <= tail_data;
        out_poison <= tail_poison;
      end
      if (wr_head_c) begin
        out_data   <= in_data;
        out_poison <= poison_c;
      end else if (push_c) begin
        tail_data   <= in_data;
        tail_poison <= poison_c;
      end
    end
  end

  // Event counters and sticky irq; set wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sbit_cnt  <= '0;
      dbit_cnt  <= '0;
      fault_cnt <= '0;
      irq       <= 1'b0;
    end else begin
      sbit_cnt  <= cnt_upd(sbit_cnt, cnt_clr, push_c & sbit_err);
      dbit_cnt  <= cnt_upd(dbit_cnt, cnt_clr, push_c & dbit_err);
      fault_cnt <= cnt_upd(fault_cnt, cnt_clr, push_c & ecc_fault);
      if (push_c && poison_c && irq_en) irq <= 1'b1;
      else if (irq_clr)                  irq <= 1'b0;
    end
  end

`ifdef ECC_145_ERR_LOG_EN
  logic any_err_c;
  assign any_err_c = sbit_err | dbit_err | ecc_fault;

  // First-error log; cnt_clr empties it but a same-cycle error is still captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_log_vld <= 1'b0;
      err_addr    <= '0;
      err_type    <= 3'b000;
    end else begin
      if (cnt_clr) err_log_vld <= 1'b0;
      if (push_c && any_err_c && (cnt_clr || !err_log_vld)) begin
        err_log_vld <= 1'b1;
        err_addr    <= in_addr;
        err_type    <= {ecc_fault, dbit_err, sbit_err};
      end
    end
  end
`else
  logic unused_addr_c;
  assign unused_addr_c = ^in_addr;
  assign err_log_vld   = 1'b0;
  assign err_addr      = '0;
  assign err_type      = 3'b000;
`endif

endmodule

// File: tb/tb_ecc_145_err_monitor.sv
// Bench for ecc_145_err_monitor: directed vector table, hand sequences and random traffic
// checked against a queue-based reference model. Honours ECC_145_ERR_LOG_EN.
module tb_ecc_145_err_monitor;

  localparam int unsigned DW  = 145;
  localparam int unsigned AW  = 8;
  localparam int unsigned CW  = 4;
  localparam int          MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_vld;
  logic          in_rdy;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          sbit_err, dbit_err, ecc_fault;
  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] out_data;
  logic          out_poison;
  logic          irq_en, irq_clr, cnt_clr;
  logic [CW-1:0] sbit_cnt, dbit_cnt, fault_cnt;
  logic          irq;
  logic          err_log_vld;
  logic [AW-1:0] err_addr;
  logic [2:0]    err_type;

  ecc_145_err_monitor #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_addr(in_addr),
    .in_data(in_data), .sbit_err(sbit_err), .dbit_err(dbit_err), .ecc_fault(ecc_fault),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_poison(out_poison),
    .irq_en(irq_en), .irq_clr(irq_clr), .cnt_clr(cnt_clr), .sbit_cnt(sbit_cnt),
    .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt), .irq(irq), .err_log_vld(err_log_vld),
    .err_addr(err_addr), .err_type(err_type)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          poison;
  } beat_t;

  // Reference model state (what the DUT should show after the last edge).
  beat_t         mq[$];
  int            m_s, m_d, m_f;
  bit            m_irq, m_logv;
  logic [AW-1:0] m_laddr;
  logic [2:0]    m_ltype;

  typedef struct {
    int vld, s, d, f, ordy, en, iclr, cclr;
    int ex_rdy, ex_ovld, ex_poi, ex_irq, ex_s, ex_d, ex_f;
  } vec_t;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [159:0] r;
    for (int i = 0; i < 5; i++) r[i*32 +: 32] = $urandom;
    return r[DW-1:0];
  endfunction

  function automatic int sat_inc(input int c);
    return (c < MAX) ? c + 1 : c;
  endfunction

  task automatic model_update(input bit vld, s, d, f, ordy, en, iclr, cclr, r,
                              input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bit acc, pop;
    if (r) begin
      mq.delete();
      m_s = 0; m_d = 0; m_f = 0;
      m_irq = 0; m_logv = 0; m_laddr = '0; m_ltype = 3'b000;
      return;
    end
    acc = vld && (mq.size() < 2);
    pop = (mq.size() > 0) && ordy;
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back('{data, d | f});
    if (cclr) begin m_s = 0; m_d = 0; m_f = 0; m_logv = 0; end
    if (acc && s) m_s = sat_inc(m_s);
    if (acc && d) m_d = sat_inc(m_d);
    if (acc && f) m_f = sat_inc(m_f);
    if (acc && (d || f) && en) m_irq = 1;
    else if (iclr)             m_irq = 0;
    if (acc && (s || d || f) && !m_logv) begin
      m_logv  = 1;
      m_laddr = addr;
      m_ltype = {f, d, s};
    end
  endtask

  task automatic check_model();
    chk("in_rdy", 160'(in_rdy), 160'(mq.size() < 2));
    chk("out_vld", 160'(out_vld), 160'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("out_data", 160'(out_data), 160'(mq[0].data));
      chk("out_poison", 160'(out_poison), 160'(mq[0].poison));
    end
    chk("sbit_cnt", 160'(sbit_cnt), 160'(m_s));
    chk("dbit_cnt", 160'(dbit_cnt), 160'(m_d));
    chk("fault_cnt", 160'(fault_cnt), 160'(m_f));
    chk("irq", 160'(irq), 160'(m_irq));
`ifdef ECC_145_ERR_LOG_EN
    chk("err_log_vld", 160'(err_log_vld), 160'(m_logv));
    if (m_logv) begin
      chk("err_addr", 160'(err_addr), 160'(m_laddr));
      chk("err_type", 160'(err_type), 160'(m_ltype));
    end
`else
    chk("err_log_off", 160'({err_log_vld, err_addr, err_type}), 160'(0));
`endif
  endtask

  // Drive one cycle of inputs (called at negedge), advance model, check at next negedge.
  task automatic step(input int vld, s, d, f, ordy, en, iclr, cclr, r, input logic [AW-1:0] addr);
    logic [DW-1:0] data;
    data      = rand_data();
    rst       = (r != 0);
    in_vld    = (vld != 0);
    sbit_err  = (s != 0);
    dbit_err  = (d != 0);
    ecc_fault = (f != 0);
    out_rdy   = (ordy != 0);
    irq_en    = (en != 0);
    irq_clr   = (iclr != 0);
    cnt_clr   = (cclr != 0);
    in_addr   = addr;
    in_data   = data;
    model_update(vld != 0, s != 0, d != 0, f != 0, ordy != 0, en != 0, iclr != 0,
                 cclr != 0, r != 0, addr, data);
    @(negedge clk);
    check_model();
  endtask

  vec_t vecs[$];

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_addr = '0; in_data = '0;
    sbit_err = 1'b0; dbit_err = 1'b0; ecc_fault = 1'b0;
    out_rdy = 1'b0; irq_en = 1'b0; irq_clr = 1'b0; cnt_clr = 1'b0;

    //             vld s d f rdy en ic cc | rdy ovld poi irq  s d f
    // clean beats streaming at full rate
    vecs.push_back('{1,0,0,0,1,0,0,0, 1,1,0,0, 0,0,0});
    vecs.push_back('{1,0,0,0,1,0,0,0, 1,1,0,0, 0,0,0});
    vecs.push_back('{1,0,0,0,1,0,0,0, 1,1,0,0, 0,0,0});
    vecs.push_back('{1,0,0,0,1,0,0,0, 1,1,0,0, 0,0,0});
    vecs.push_back('{0,0,0,0,1,0,0,0, 1,0,0,0, 0,0,0});
    // back-pressure: fill, stall third beat, drain
    vecs.push_back('{1,0,0,0,0,0,0,0, 1,1,0,0, 0,0,0});
    vecs.push_back('{1,0,0,0,0,0,0,0, 0,1,0,0, 0,0,0});
    vecs.push_back('{1,0,0,0,0,0,0,0, 0,1,0,0, 0,0,0});
    vecs.push_back('{1,0,0,0,1,0,0,0, 1,1,0,0, 0,0,0});
    vecs.push_back('{1,0,0,0,1,0,0,0, 1,1,0,0, 0,0,0});
    vecs.push_back('{0,0,0,0,1,0,0,0, 1,0,0,0, 0,0,0});
    // sbit then dbit with irq enabled
    vecs.push_back('{1,1,0,0,1,1,0,0, 1,1,0,0, 1,0,0});
    vecs.push_back('{1,0,1,0,1,1,0,0, 1,1,1,1, 1,1,0});
    vecs.push_back('{0,0,0,0,1,0,0,0, 1,0,0,1, 1,1,0});
    // irq_clr alone, then irq_clr colliding with a fault beat, then alone again
    vecs.push_back('{0,0,0,0,1,0,1,0, 1,0,0,0, 1,1,0});
    vecs.push_back('{1,0,0,1,1,1,1,0, 1,1,1,1, 1,1,1});
    vecs.push_back('{0,0,0,0,1,0,1,0, 1,0,0,0, 1,1,1});
    // irq_en low blocks set; irq holds once en drops
    vecs.push_back('{1,0,1,0,1,0,0,0, 1,1,1,0, 1,2,1});
    vecs.push_back('{1,0,0,1,1,1,0,0, 1,1,1,1, 1,2,2});
    vecs.push_back('{0,0,0,0,1,0,0,0, 1,0,0,1, 1,2,2});
    // flags on a refused beat are ignored
    vecs.push_back('{1,0,0,0,0,0,0,0, 1,1,0,1, 1,2,2});
    vecs.push_back('{1,0,0,0,0,0,0,0, 0,1,0,1, 1,2,2});
    vecs.push_back('{1,1,1,1,0,1,0,0, 0,1,0,1, 1,2,2});
    vecs.push_back('{0,0,0,0,1,0,0,0, 1,1,0,1, 1,2,2});
    vecs.push_back('{0,0,0,0,1,0,0,0, 1,0,0,1, 1,2,2});
    // all flags on one beat, then clear counters (irq untouched)
    vecs.push_back('{1,1,1,1,1,1,0,0, 1,1,1,1, 2,3,3});
    vecs.push_back('{0,0,0,0,1,0,0,1, 1,0,0,1, 0,0,0});

    @(negedge clk);
    step(0,0,0,0,0,0,0,0,1, 8'h00);
    step(0,0,0,0,0,0,0,0,1, 8'h00);
    chk("reset_out_data", 160'(out_data), 160'(0));
    chk("reset_out_poison", 160'(out_poison), 160'(0));

    foreach (vecs[i]) begin
      step(vecs[i].vld, vecs[i].s, vecs[i].d, vecs[i].f, vecs[i].ordy, vecs[i].en,
           vecs[i].iclr, vecs[i].cclr, 0, 8'($urandom));
      chk($sformatf("vec%0d_in_rdy", i), 160'(in_rdy), 160'(vecs[i].ex_rdy));
      chk($sformatf("vec%0d_out_vld", i), 160'(out_vld), 160'(vecs[i].ex_ovld));
      if (vecs[i].ex_ovld != 0)
        chk($sformatf("vec%0d_poison", i), 160'(out_poison), 160'(vecs[i].ex_poi));
      chk($sformatf("vec%0d_irq", i), 160'(irq), 160'(vecs[i].ex_irq));
      chk($sformatf("vec%0d_sbit", i), 160'(sbit_cnt), 160'(vecs[i].ex_s));
      chk($sformatf("vec%0d_dbit", i), 160'(dbit_cnt), 160'(vecs[i].ex_d));
      chk($sformatf("vec%0d_fault", i), 160'(fault_cnt), 160'(vecs[i].ex_f));
    end

    // Saturation, then clear colliding with a counted beat
    for (int i = 0; i < 20; i++) step(1,1,0,0,1,0,0,0,0, 8'($urandom));
    chk("sbit_saturated", 160'(sbit_cnt), 160'(15));
    step(1,1,0,0,1,0,0,1,0, 8'h77);
    chk("sbit_clr_plus_event", 160'(sbit_cnt), 160'(1));

    // First-error log
    step(0,0,0,0,1,0,0,1,0, 8'h00);
    step(1,1,0,0,1,0,0,0,0, 8'h12);
    step(1,0,1,0,1,0,0,0,0, 8'h34);
    step(0,0,0,0,1,0,0,0,0, 8'h00);
`ifdef ECC_145_ERR_LOG_EN
    chk("log_first_vld", 160'(err_log_vld), 160'(1));
    chk("log_first_addr", 160'(err_addr), 160'(8'h12));
    chk("log_first_type", 160'(err_type), 160'(3'b001));
`else
    chk("log_off_after_err", 160'({err_log_vld, err_addr, err_type}), 160'(0));
`endif
    step(1,0,0,1,1,0,0,1,0, 8'h56);
`ifdef ECC_145_ERR_LOG_EN
    chk("log_clr_capture_vld", 160'(err_log_vld), 160'(1));
    chk("log_clr_capture_addr", 160'(err_addr), 160'(8'h56));
    chk("log_clr_capture_type", 160'(err_type), 160'(3'b100));
`endif
    step(0,0,0,0,1,0,0,1,0, 8'h00);
    chk("log_cleared", 160'(err_log_vld), 160'(0));

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(int'($urandom_range(0, 9) < 7), int'($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 9) == 0), int'($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 9) < 6), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 19) == 0), int'($urandom_range(0, 49) == 0),
           int'($urandom_range(0, 99) == 0), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
